// File: rtl/arb_pkg.sv
// Shared types and constants for the 16-way priority arbiter.
// Also provides the helper that formats a grant index into the encoder's 8-bit code.
package arb_pkg;

    localparam int unsigned NUM_REQ   = 16;
    localparam int unsigned ID_W      = 4;
    localparam logic [7:0]  IDLE_CODE = 8'hF0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    function automatic logic [7:0] make_code(input logic [ID_W-1:0] id);
        return {4'h0, id};
    endfunction

endpackage

// File: rtl/prio_enc16.sv
// Combinational 16-input priority encoder searching downward from a start index.
// The search wraps, so index 0 is followed by index 15.
module prio_enc16
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_vec,
    input  logic [ID_W-1:0]    i_start,
    output logic               o_found,
    output logic [ID_W-1:0]    o_idx
);

    logic [ID_W-1:0] w_cand;

    // Walk from the farthest candidate toward i_start so the nearest hit is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = i_start - ID_W'(i);
            if (i_vec[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// Sequential 16-way arbiter: one grant at a time, held until done, withdrawal or hold timeout.
// Optional macro ROUND_ROBIN_EN rotates the search start past the previous winner.
//
// state | meaning
// IDLE  | no grant, sampling requests
// BUSY  | grant held, hold counter running
// GAP   | one dead cycle after any release
module prio_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 255
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       done,
    output logic       gnt_valid,
    output logic [3:0] gnt_id,
    output logic [7:0] gnt_code,
    output logic       timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    arb_state_e          r_state;
    logic [7:0]          r_hold_cnt;
    logic                r_gnt_valid;
    logic [ID_W-1:0]     r_gnt_id;
    logic [7:0]          r_gnt_code;
    logic                r_timeout;

    logic [NUM_REQ-1:0]  w_req;
    logic [ID_W-1:0]     w_start;
    logic                w_found;
    logic [ID_W-1:0]     w_winner;

    assign w_req = {req_a, req_b};

`ifdef ROUND_ROBIN_EN
    logic [ID_W-1:0] r_last_id;

    assign w_start = r_last_id - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_id <= 4'd15;
        end else if (r_state == IDLE && w_found) begin
            r_last_id <= w_winner;
        end
    end
`else
    assign w_start = 4'd15;
`endif

    prio_enc16 u_enc (
        .i_vec   (w_req),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hold_cnt  <= 8'd0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_gnt_code  <= IDLE_CODE;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state     <= BUSY;
                        r_hold_cnt  <= 8'd0;
                        r_gnt_valid <= 1'b1;
                        r_gnt_id    <= w_winner;
                        r_gnt_code  <= make_code(w_winner);
                    end
                end
                BUSY: begin
                    // Release priority: done, then withdrawal, then hold expiry.
                    if (done || !w_req[r_gnt_id] || r_hold_cnt == HOLD_LAST) begin
                        r_state     <= GAP;
                        r_gnt_valid <= 1'b0;
                        r_gnt_id    <= '0;
                        r_gnt_code  <= IDLE_CODE;
                        r_timeout   <= !done && w_req[r_gnt_id];
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_gnt_valid <= 1'b0;
                    r_gnt_id    <= '0;
                    r_gnt_code  <= IDLE_CODE;
                end
            endcase
        end
    end

    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;
    assign gnt_code  = r_gnt_code;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed self-checking bench for prio_arbiter with a short hold limit.
// Expectations follow ROUND_ROBIN_EN when the bench is built with it.
module tb_prio_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       done;
    logic       gnt_valid;
    logic [3:0] gnt_id;
    logic [7:0] gnt_code;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    prio_arbiter #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .gnt_code  (gnt_code),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [15:0] r);
        {req_a, req_b} = r;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_valid"}, 32'(gnt_valid), 32'd0);
        check({tag, "_id"},    32'(gnt_id),    32'd0);
        check({tag, "_code"},  32'(gnt_code),  32'hF0);
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] id);
        check({tag, "_valid"}, 32'(gnt_valid), 32'd1);
        check({tag, "_id"},    32'(gnt_id),    32'(id));
        check({tag, "_code"},  32'(gnt_code),  {28'h0, id});
    endtask

    initial begin
        rst  = 1'b1;
        done = 1'b0;
        set_req(16'h0000);
        #12;
        chk_idle("rst");
        check("rst_to", 32'(timeout), 32'd0);
        tick();
        rst = 1'b0;

        // quiet bus
        for (int i = 0; i < 10; i++) begin
            tick();
            check("quiet_valid", 32'(gnt_valid), 32'd0);
            check("quiet_code",  32'(gnt_code),  32'hF0);
        end

        // two requesters, highest index first in both modes
        set_req(16'h0104);
        tick();
        chk_grant("g8", 4'd8);
        done = 1'b1;
        tick();
        done = 1'b0;
        set_req(16'h0004);
        chk_idle("g8_rel");
        check("g8_rel_to", 32'(timeout), 32'd0);
        tick();
        check("gap_valid", 32'(gnt_valid), 32'd0);
        tick();
        chk_grant("g2", 4'd2);
        set_req(16'h0000);
        tick();
        chk_idle("g2_abort");
        tick();

        // hold timeout with HOLD_MAX=4
        set_req(16'h8000);
        tick();
        chk_grant("to_c1", 4'd15);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("to_hold_valid", 32'(gnt_valid), 32'd1);
            check("to_hold_to",    32'(timeout),   32'd0);
        end
        tick();
        chk_idle("to_rel");
        check("to_pulse", 32'(timeout), 32'd1);
        tick();
        check("to_pulse_end", 32'(timeout), 32'd0);
        check("to_idle_valid", 32'(gnt_valid), 32'd0);
        tick();
        chk_grant("to_regrant", 4'd15);
        set_req(16'h0000);
        tick();
        tick();

        // requester withdraws mid-grant
        set_req(16'h0020);
        tick();
        chk_grant("g5", 4'd5);
        tick();
        check("g5_hold", 32'(gnt_valid), 32'd1);
        set_req(16'h0001);
        tick();
        chk_idle("g5_drop");
        check("g5_drop_to", 32'(timeout), 32'd0);
        set_req(16'h0000);
        tick();

        // done on the final hold cycle wins over expiry
        set_req(16'h0200);
        tick();
        chk_grant("g9", 4'd9);
        tick();
        tick();
        tick();
        check("g9_last", 32'(gnt_valid), 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_idle("g9_rel");
        check("g9_rel_to", 32'(timeout), 32'd0);
        tick();

        // alternating contenders, done on every grant
        set_req(16'h8001);
        for (int n = 0; n < 4; n++) begin
            logic [3:0] exp_id;
`ifdef ROUND_ROBIN_EN
            exp_id = (n % 2 == 0) ? 4'd0 : 4'd15;
`else
            exp_id = 4'd15;
`endif
            tick();
            chk_grant("seq", exp_id);
            done = 1'b1;
            tick();
            done = 1'b0;
            check("seq_rel", 32'(gnt_valid), 32'd0);
            tick();
        end
        set_req(16'h0000);
        tick();

        // asynchronous reset mid-grant
        set_req(16'h0040);
        tick();
        chk_grant("g6", 4'd6);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("arst");
        check("arst_to", 32'(timeout), 32'd0);
        tick();
        rst = 1'b0;
        check("arst_hold", 32'(gnt_valid), 32'd0);
        tick();
        chk_grant("post_rst", 4'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
